// File: rtl/ntt_twiddle_gen.sv
// ntt_twiddle_gen: derives the N-th root of unity by repeated squaring, then fills a
// table with its powers using one shared bit-serial modular multiplier.
module ntt_twiddle_gen #(
    parameter int WIDTH = 64,
    parameter logic [WIDTH-1:0] P = 64'd4179340454199820289,
    parameter logic [WIDTH-1:0] OMEGA = 64'd68630377364883,
    parameter int LOG_ROOT = 57,
    parameter int LOG_MAX_N = 6,
    parameter int LW = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LW-1:0]          log_n,
    output logic                   busy,
    output logic                   done,
    output logic                   ready,
    output logic                   err,
    input  logic [LOG_MAX_N-2:0]   rd_addr,
    output logic [WIDTH-1:0]       rd_data
);
    localparam int DEPTH = 2 ** (LOG_MAX_N - 1);
    localparam int CW = $clog2(LOG_ROOT + 1);
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ROOT, FILL, FIN} state_t;

    state_t               state;
    logic [WIDTH-1:0]     w, acc, prod, wr_data;
    logic [WIDTH+1:0]     r, sum, s1;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bitc;
    logic [LOG_MAX_N-1:0] k, half;
    logic [LW-1:0]        ln;
    logic                 first, last, wr_en;
    logic [LOG_MAX_N-2:0] wr_addr;
    logic [WIDTH-1:0]     mem [DEPTH];

    // One interleaved step: r = 2r + a*b[bit], then at most two subtractions of P.
    always_comb begin
        sum = (r << 1) + (w[bitc] ? {2'b0, state == FILL ? acc : w} : '0);
        s1 = sum >= {2'b0, P} ? sum - {2'b0, P} : sum;
        prod = WIDTH'(s1 >= {2'b0, P} ? s1 - {2'b0, P} : s1);
        last = bitc == '0;
        half = LOG_MAX_N'(1) << (ln - 1'b1);
        wr_en = state == FILL && (first || (k != half && last));
        wr_addr = first ? '0 : k[LOG_MAX_N-2:0];
        wr_data = first ? WIDTH'(1) : prod;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= rst ? '0 : mem[rd_addr];
    end

    // bitc wraps from 0 back to WIDTH-1, so each product restarts at the MSB on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            ready <= 1'b0;
            err <= 1'b0;
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (log_n != '0 && log_n <= LW'(LOG_MAX_N)) begin
                        ln <= log_n;
                        cnt <= CW'(LOG_ROOT) - CW'(log_n);
                        w <= OMEGA;
                        r <= '0;
                        bitc <= BW'(WIDTH - 1);
                        ready <= 1'b0;
                        busy <= 1'b1;
                        state <= ROOT;
                    end else begin
                        err <= 1'b1;
                    end
                end
                ROOT: if (cnt == '0) begin
                    first <= 1'b1;
                    state <= FILL;
                end else begin
                    r <= last ? '0 : {2'b0, prod};
                    bitc <= bitc - 1'b1;
                    if (last) begin
                        w <= prod;
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            first <= 1'b1;
                            state <= FILL;
                        end
                    end
                end
                FILL: if (first) begin
                    first <= 1'b0;
                    acc <= WIDTH'(1);
                    k <= LOG_MAX_N'(1);
                end else if (k == half) begin
                    done <= 1'b1;
                    ready <= 1'b1;
                    busy <= 1'b0;
                    state <= FIN;
                end else begin
                    r <= last ? '0 : {2'b0, prod};
                    bitc <= bitc - 1'b1;
                    if (last) begin
                        acc <= prod;
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_twiddle_gen.sv
// tb_ntt_twiddle_gen: scoreboard bench driving a small (P=97) and the default instance
// against a modular-exponentiation reference model.
module tb_ntt_twiddle_gen;
    localparam logic [63:0] BP = 64'd4179340454199820289;
    localparam logic [63:0] BOM = 64'd68630377364883;

    logic clk = 0;
    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic s_rst, s_start, s_busy, s_done, s_ready, s_err;
    logic [2:0] s_log_n;
    logic [3:0] s_rd_addr;
    logic [7:0] s_rd_data;
    logic b_rst, b_start, b_busy, b_done, b_ready, b_err;
    logic [2:0] b_log_n;
    logic [4:0] b_rd_addr;
    logic [63:0] b_rd_data;

    ntt_twiddle_gen #(.WIDTH(8), .P(8'd97), .OMEGA(8'd28), .LOG_ROOT(5), .LOG_MAX_N(5), .LW(3)) u_s (
        .clk(clk), .rst(s_rst), .start(s_start), .log_n(s_log_n), .busy(s_busy), .done(s_done),
        .ready(s_ready), .err(s_err), .rd_addr(s_rd_addr), .rd_data(s_rd_data));

    ntt_twiddle_gen u_b (
        .clk(clk), .rst(b_rst), .start(b_start), .log_n(b_log_n), .busy(b_busy), .done(b_done),
        .ready(b_ready), .err(b_err), .rd_addr(b_rd_addr), .rd_data(b_rd_data));

    logic [63:0] s_rq[$], b_rq[$];
    int s_dq[$], b_dq[$];
    logic s_req = 0, b_req = 0, s_req_d = 0, b_req_d = 0;
    always @(posedge clk) begin
        s_req_d <= s_req;
        b_req_d <= b_req;
    end

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", n, a, e);
        end
    endtask

    function automatic logic [63:0] mm(logic [63:0] a, logic [63:0] b, logic [63:0] p);
        logic [127:0] t;
        t = ({64'd0, a} * {64'd0, b}) % {64'd0, p};
        return t[63:0];
    endfunction

    function automatic logic [63:0] mpow(logic [63:0] b, logic [63:0] e, logic [63:0] p);
        logic [63:0] r = 1;
        while (e != 0) begin
            if (e[0]) r = mm(r, b, p);
            b = mm(b, b, p);
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic logic [63:0] root(int big, int ln);
        return big ? mpow(BOM, 64'd1 << (57 - ln), BP) : mpow(64'd28, 64'd1 << (5 - ln), 64'd97);
    endfunction

    function automatic int lat(int big, int ln);
        int s = (big ? 57 : 5) - ln;
        return 2 + (s + (1 << (ln - 1)) - 1) * (big ? 64 : 8) + (s == 0 ? 1 : 0);
    endfunction

    // Monitor: pops expected read data and expected done cycles as the DUTs present them.
    always @(negedge clk) begin
        if (s_req_d) chk("s_rd", 64'(s_rd_data), s_rq.pop_front());
        if (b_req_d) chk("b_rd", b_rd_data, b_rq.pop_front());
        if (s_done) chk("s_done_cyc", 64'(cyc), s_dq.size() != 0 ? 64'(s_dq.pop_front()) : '1);
        if (b_done) chk("b_done_cyc", 64'(cyc), b_dq.size() != 0 ? 64'(b_dq.pop_front()) : '1);
    end

    task automatic go(int big, int ln, int ok);
        @(negedge clk);
        if (big) begin b_log_n = 3'(ln); b_start = 1; end
        else begin s_log_n = 3'(ln); s_start = 1; end
        if (ok) begin
            if (big) b_dq.push_back(cyc + 1 + lat(big, ln));
            else s_dq.push_back(cyc + 1 + lat(big, ln));
        end
        @(negedge clk);
        s_start = 0;
        b_start = 0;
    endtask

    // Waits for done; for the first m cycles the small instance gets random start pulses.
    task automatic wait_done(int big, int m);
        int n = 0;
        while (!(big ? b_done : s_done) && n < 6000) begin
            if (!big) begin
                s_start = n < m ? 1'($urandom) : 1'b0;
                s_log_n = 3'($urandom);
                if (s_err) chk("s_err_busy", 1, 0);
            end
            @(negedge clk);
            n++;
        end
        s_start = 0;
        if (n >= 6000) begin
            chk(big ? "b_timeout" : "s_timeout", 0, 1);
            if (big) b_dq.delete(); else s_dq.delete();
        end
    endtask

    task automatic read_all(int big, int ln, int cnt, int rnd);
        int half = 1 << (ln - 1);
        for (int i = 0; i < cnt; i++) begin
            int k = rnd ? int'($urandom_range(0, half - 1)) : i;
            @(negedge clk);
            if (big) begin
                b_rd_addr = 5'(k); b_req = 1; b_rq.push_back(mpow(root(1, ln), 64'(k), BP));
            end else begin
                s_rd_addr = 4'(k); s_req = 1; s_rq.push_back(mpow(root(0, ln), 64'(k), 64'd97));
            end
        end
        @(negedge clk);
        s_req = 0;
        b_req = 0;
    endtask

    initial begin
        logic pr;
        int ln;
        int inv_big[5] = '{0, 0, 0, 1, 1};
        int inv_ln[5] = '{0, 6, 7, 0, 7};
        s_rst = 1; b_rst = 1; s_start = 0; b_start = 0;
        s_log_n = 0; b_log_n = 0; s_rd_addr = 0; b_rd_addr = 0;
        repeat (3) @(negedge clk);
        chk("s_rst_busy", 64'(s_busy), 0); chk("s_rst_done", 64'(s_done), 0);
        chk("s_rst_ready", 64'(s_ready), 0); chk("s_rst_err", 64'(s_err), 0);
        chk("s_rst_rd", 64'(s_rd_data), 0); chk("b_rst_busy", 64'(b_busy), 0);
        chk("b_rst_ready", 64'(b_ready), 0); chk("b_rst_rd", b_rd_data, 0);
        s_rst = 0; b_rst = 0;

        go(0, 3, 1); wait_done(0, 0);
        chk("s_ready_fin", 64'(s_ready), 1); chk("s_busy_fin", 64'(s_busy), 0);
        read_all(0, 3, 4, 0);
        go(0, 5, 1); wait_done(0, 0); read_all(0, 5, 16, 0);

        go(1, 1, 1); wait_done(1, 0); read_all(1, 1, 1, 0);
        go(1, 6, 1); wait_done(1, 0); read_all(1, 6, 32, 0);
        @(negedge clk); b_rd_addr = 31;
        @(negedge clk); chk("b_t31_w", mm(b_rd_data, root(1, 6), BP), BP - 1);

        for (int i = 0; i < 5; i++) begin
            pr = inv_big[i] ? b_ready : s_ready;
            go(inv_big[i], inv_ln[i], 0);
            chk("inv_err", 64'(inv_big[i] ? b_err : s_err), 1);
            chk("inv_busy", 64'(inv_big[i] ? b_busy : s_busy), 0);
            chk("inv_ready", 64'(inv_big[i] ? b_ready : s_ready), 64'(pr));
            @(negedge clk);
            chk("inv_err_pulse", 64'(inv_big[i] ? b_err : s_err), 0);
        end

        go(0, 3, 1);
        repeat (25) @(negedge clk);
        s_rst = 1;
        @(negedge clk);
        s_rst = 0;
        s_dq.delete();
        chk("abort_busy", 64'(s_busy), 0); chk("abort_ready", 64'(s_ready), 0);
        chk("abort_done", 64'(s_done), 0);
        repeat (30) @(negedge clk);
        go(0, 3, 1); wait_done(0, 30); read_all(0, 3, 4, 0);

        go(0, 3, 1); wait_done(0, 0);
        go(0, 4, 1);
        chk("b2b_ready_drop", 64'(s_ready), 0); chk("b2b_busy", 64'(s_busy), 1);
        wait_done(0, 0); read_all(0, 4, 8, 0);

        repeat (4) begin
            ln = int'($urandom_range(1, 5));
            go(0, ln, 1); wait_done(0, 0); read_all(0, ln, 6, 1);
        end

        repeat (3) @(negedge clk);
        chk("s_done_left", 64'(s_dq.size()), 0);
        chk("b_done_left", 64'(b_dq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
